ball_motion: RTL and testbench

//  Ball position/velocity engine; consumer of the paddle stage's paddleX.

---
 rtl/ball_motion_pkg.sv | 39 +++
 rtl/ball_motion_if.sv | 23 ++
 rtl/ball_motion_paddle_hit_detect.sv | 45 ++++
 rtl/ball_motion.sv | 197 +++++++++++++++++++
 tb/tb_ball_motion.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ball_motion_pkg.sv
// Shared definitions for the ball motion engine: game-state codes,
// playfield defaults, FSM and paddle-zone encodings, and the serve-column helper.
package ball_motion_pkg;

  localparam int SCREEN_W_DEFAULT = 160;
  localparam int SCREEN_H_DEFAULT = 120;
  localparam int PADDLE_Y_DEFAULT = 110;

  // Game state codes driven by the upstream game controller
  localparam logic [2:0] ST_SERVE = 3'b000;
  localparam logic [2:0] ST_PLAY  = 3'b001;

  typedef enum logic [1:0] {
    FSM_SERVE = 2'b00,
    FSM_MOVE  = 2'b01,
    FSM_LOST  = 2'b10
  } fsm_e;

  // Which part of the paddle the ball struck
  typedef enum logic [1:0] {
    ZONE_MID   = 2'b00,
    ZONE_LEFT  = 2'b01,
    ZONE_RIGHT = 2'b10
  } zone_e;

  // Ball column while sitting on the paddle: paddle centre, clamped to the right edge
  function automatic logic [7:0] serve_column(input logic [7:0] paddle_x,
                                              input logic [7:0] paddle_len,
                                              input logic [7:0] x_max);
    logic [8:0] sum_s;
    sum_s = {1'b0, paddle_x} + {2'b00, paddle_len[7:1]};
    if (sum_s >= {1'b0, x_max}) begin
      return x_max;
    end else begin
      return sum_s[7:0];
    end
  endfunction

endpackage

// File: rtl/ball_motion_if.sv
// Signal bundle between the game controller / paddle stage and the ball engine.
// master: drives strobes and paddle geometry, slave: the ball engine.
interface ball_motion_if;
  logic       tick;
  logic [2:0] state;
  logic [7:0] paddleX;
  logic [7:0] length;
  logic       brickHit;
  logic [7:0] ballX;
  logic [6:0] ballY;
  logic       paddleHit;
  logic       lostBall;

  modport master (
    output tick, state, paddleX, length, brickHit,
    input  ballX, ballY, paddleHit, lostBall
  );

  modport slave (
    input  tick, state, paddleX, length, brickHit,
    output ballX, ballY, paddleHit, lostBall
  );
endinterface

// File: rtl/ball_motion_paddle_hit_detect.sv
// Paddle overlap test: the ball hits when it is descending on the row just
// above the paddle and its column lies within the paddle span. Also reports
// whether the contact point is in the outer quarter on either side.
module ball_motion_paddle_hit_detect
  import ball_motion_pkg::*;
#(
  parameter int PADDLE_Y = PADDLE_Y_DEFAULT
) (
  input  logic [7:0] ball_x,
  input  logic [6:0] ball_y,
  input  logic       dy_down,
  input  logic [7:0] paddle_x,
  input  logic [7:0] paddle_len,
  output logic       hit,
  output zone_e      zone
);

  localparam logic [6:0] Y_REST = 7'(PADDLE_Y - 1);

  logic [8:0] right_edge_s;
  logic [8:0] offset_s;
  logic [8:0] quarter_s;
  logic [8:0] outer_start_s;
  logic       in_span_s;

  // Span test in 9 bits so paddle_x+length cannot wrap, then zone classification
  always_comb begin
    right_edge_s  = {1'b0, paddle_x} + {1'b0, paddle_len} - 9'd1;
    offset_s      = {1'b0, ball_x} - {1'b0, paddle_x};
    quarter_s     = {3'b000, paddle_len[7:2]};
    outer_start_s = {1'b0, paddle_len} - quarter_s;
    in_span_s     = ({1'b0, ball_x} >= {1'b0, paddle_x}) && ({1'b0, ball_x} <= right_edge_s);
    hit           = dy_down && (ball_y == Y_REST) && in_span_s;
    if (!hit) begin
      zone = ZONE_MID;
    end else if (offset_s < quarter_s) begin
      zone = ZONE_LEFT;
    end else if (offset_s >= outer_start_s) begin
      zone = ZONE_RIGHT;
    end else begin
      zone = ZONE_MID;
    end
  end

endmodule

// File: rtl/ball_motion.sv
// Ball position/velocity engine. Holds the ball on the paddle while serving,
// steps it once per frame tick while playing, reflects it off walls and the
// paddle, and reports paddle bounces and lost balls as one-cycle pulses.
// Optional feature macro BALL_ANGLE_EN: paddle hits in the outer quarter of the
// paddle send the ball away at horizontal speed 2.
module ball_motion
  import ball_motion_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEFAULT,
  parameter int SCREEN_H = SCREEN_H_DEFAULT,
  parameter int PADDLE_Y = PADDLE_Y_DEFAULT
) (
  input logic          clock,
  input logic          resetn,
  ball_motion_if.slave bus
);

  localparam logic [7:0] X_MAX    = 8'(SCREEN_W - 1);
  localparam logic [6:0] Y_MAX    = 7'(SCREEN_H - 1);
  localparam logic [6:0] Y_REST   = 7'(PADDLE_Y - 1);
  localparam logic [6:0] Y_BOUNCE = 7'(PADDLE_Y - 2);

  fsm_e              fsm_r;
  logic [7:0]        ball_x_r;
  logic [6:0]        ball_y_r;
  logic signed [2:0] dx_r;
  logic              dy_down_r;      // 1: dy=+1 (towards paddle), 0: dy=-1
  logic              brick_r;        // pending brick reversal
  logic              paddle_hit_r;
  logic              lost_ball_r;

  logic [7:0]        serve_x_s;
  logic              hit_s;
  zone_e             zone_s;
  logic signed [9:0] nx_s;
  logic signed [9:0] ny_s;
  logic [7:0]        step_x_s;
  logic signed [2:0] wall_dx_s;
  logic signed [2:0] step_dx_s;
  logic [6:0]        step_y_s;
  logic              step_dy_down_s;
  logic              step_hit_s;
  logic              step_lost_s;

  assign serve_x_s = serve_column(bus.paddleX, bus.length, X_MAX);

  ball_motion_paddle_hit_detect #(
    .PADDLE_Y (PADDLE_Y)
  ) u_hit (
    .ball_x     (ball_x_r),
    .ball_y     (ball_y_r),
    .dy_down    (dy_down_r),
    .paddle_x   (bus.paddleX),
    .paddle_len (bus.length),
    .hit        (hit_s),
    .zone       (zone_s)
  );

  // Candidate next position with signed headroom so walls can be detected past the edge
  always_comb begin
    nx_s = $signed({2'b00, ball_x_r}) + $signed({{7{dx_r[2]}}, dx_r});
    if (dy_down_r) begin
      ny_s = $signed({3'b000, ball_y_r}) + 10'sd1;
    end else begin
      ny_s = $signed({3'b000, ball_y_r}) - 10'sd1;
    end
  end

  // Horizontal step: side-wall clamp and reflection, then paddle steering
  always_comb begin
    if (nx_s <= 10'sd0) begin
      step_x_s  = 8'd0;
      wall_dx_s = -dx_r;
    end else if (nx_s >= $signed({2'b00, X_MAX})) begin
      step_x_s  = X_MAX;
      wall_dx_s = -dx_r;
    end else begin
      step_x_s  = nx_s[7:0];
      wall_dx_s = dx_r;
    end
`ifdef BALL_ANGLE_EN
    if (hit_s) begin
      case (zone_s)
        ZONE_LEFT:  step_dx_s = -3'sd2;
        ZONE_RIGHT: step_dx_s = 3'sd2;
        default:    step_dx_s = wall_dx_s[2] ? -3'sd1 : 3'sd1;
      endcase
    end else begin
      step_dx_s = wall_dx_s;
    end
`else
    step_dx_s = wall_dx_s;
`endif
  end

`ifndef BALL_ANGLE_EN
  // Zone only steers the ball when angled bounces are built in
  logic unused_zone_s;
  assign unused_zone_s = ^zone_s;
`endif

  // Vertical step: top wall and paddle win over a pending brick reversal
  always_comb begin
    step_y_s       = ny_s[6:0];
    step_dy_down_s = dy_down_r;
    step_hit_s     = 1'b0;
    step_lost_s    = 1'b0;
    if (ny_s <= 10'sd0) begin
      step_y_s       = 7'd0;
      step_dy_down_s = 1'b1;
    end else if (hit_s) begin
      step_y_s       = Y_BOUNCE;
      step_dy_down_s = 1'b0;
      step_hit_s     = 1'b1;
    end else if (ny_s >= $signed({3'b000, Y_MAX})) begin
      step_y_s       = Y_MAX;
      step_lost_s    = 1'b1;
      step_dy_down_s = dy_down_r ^ brick_r;
    end else begin
      step_y_s       = ny_s[6:0];
      step_dy_down_s = dy_down_r ^ brick_r;
    end
  end

  // Serve/move/lost sequencer owning all ball state and the output pulses
  always_ff @(posedge clock) begin
    if (!resetn) begin
      fsm_r        <= FSM_SERVE;
      ball_x_r     <= serve_x_s;
      ball_y_r     <= Y_REST;
      dx_r         <= 3'sd1;
      dy_down_r    <= 1'b0;
      brick_r      <= 1'b0;
      paddle_hit_r <= 1'b0;
      lost_ball_r  <= 1'b0;
    end else begin
      paddle_hit_r <= 1'b0;
      lost_ball_r  <= 1'b0;
      case (fsm_r)
        FSM_SERVE: begin
          ball_x_r  <= serve_x_s;
          ball_y_r  <= Y_REST;
          dx_r      <= 3'sd1;
          dy_down_r <= 1'b0;
          brick_r   <= 1'b0;
          if (bus.state == ST_PLAY) begin
            fsm_r <= FSM_MOVE;
          end else begin
            fsm_r <= FSM_SERVE;
          end
        end
        FSM_MOVE: begin
          if (bus.state == ST_SERVE) begin
            fsm_r     <= FSM_SERVE;
            ball_x_r  <= serve_x_s;
            ball_y_r  <= Y_REST;
            dx_r      <= 3'sd1;
            dy_down_r <= 1'b0;
            brick_r   <= 1'b0;
          end else if ((bus.state == ST_PLAY) && bus.tick) begin
            ball_x_r     <= step_x_s;
            ball_y_r     <= step_y_s;
            dx_r         <= step_dx_s;
            dy_down_r    <= step_dy_down_s;
            brick_r      <= bus.brickHit;
            paddle_hit_r <= step_hit_s;
            lost_ball_r  <= step_lost_s;
            fsm_r        <= step_lost_s ? FSM_LOST : FSM_MOVE;
          end else begin
            brick_r <= brick_r | bus.brickHit;
          end
        end
        FSM_LOST: begin
          if (bus.state == ST_SERVE) begin
            fsm_r     <= FSM_SERVE;
            ball_x_r  <= serve_x_s;
            ball_y_r  <= Y_REST;
            dx_r      <= 3'sd1;
            dy_down_r <= 1'b0;
            brick_r   <= 1'b0;
          end else begin
            fsm_r <= FSM_LOST;
          end
        end
        default: begin
          fsm_r <= FSM_SERVE;
        end
      endcase
    end
  end

  assign bus.ballX     = ball_x_r;
  assign bus.ballY     = ball_y_r;
  assign bus.paddleHit = paddle_hit_r;
  assign bus.lostBall  = lost_ball_r;

endmodule

// File: tb/tb_ball_motion.sv
// Self-checking bench for ball_motion: directed scenarios with hand-derived
// positions, then randomized play checked against an integer-arithmetic model.
module tb_ball_motion;

  logic clock = 1'b0;
  logic resetn;
  ball_motion_if bus();

  ball_motion dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  // 100 MHz-style free-running clock
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model: plain integers, dy as +1/-1, mode 0 serve / 1 move / 2 lost
  int m_mode, m_x, m_y, m_dx, m_dy;
  bit m_brick, m_phit, m_lost;

  function automatic int serve_pos(int px, int len);
    int s;
    s = px + len / 2;
    return (s > 159) ? 159 : s;
  endfunction

  task automatic model_serve();
    m_x = serve_pos(int'(bus.paddleX), int'(bus.length));
    m_y = 109; m_dx = 1; m_dy = -1; m_brick = 0;
  endtask

  task automatic model_edge();
    int nx, ny, ndx, ndy, px, len, q, off;
    bit hit, flip;
    px = int'(bus.paddleX);
    len = int'(bus.length);
    m_phit = 0; m_lost = 0;
    if (resetn !== 1'b1) begin
      model_serve(); m_mode = 0;
    end else if (m_mode == 0) begin
      model_serve();
      if (bus.state == 3'b001) m_mode = 1;
    end else if (m_mode == 1) begin
      if (bus.state == 3'b000) begin
        model_serve(); m_mode = 0;
      end else if (bus.state == 3'b001 && bus.tick) begin
        nx = m_x + m_dx; ny = m_y + m_dy;
        hit = (m_dy > 0) && (m_y == 109) && (m_x >= px) && (m_x <= px + len - 1);
        off = m_x - px;
        q = len / 4;
        flip = m_brick; ndx = m_dx; ndy = m_dy;
        if (nx <= 0) begin m_x = 0; ndx = -m_dx; end
        else if (nx >= 159) begin m_x = 159; ndx = -m_dx; end
        else m_x = nx;
`ifdef BALL_ANGLE_EN
        if (hit) begin
          if (off < q) ndx = -2;
          else if (off >= len - q) ndx = 2;
          else ndx = (ndx < 0) ? -1 : 1;
        end
`endif
        if (ny <= 0) begin m_y = 0; ndy = 1; flip = 0; end
        else if (hit) begin m_y = 108; ndy = -1; m_phit = 1; flip = 0; end
        else if (ny >= 119) begin m_y = 119; m_lost = 1; m_mode = 2; end
        else m_y = ny;
        if (flip) ndy = -ndy;
        m_dx = ndx; m_dy = ndy;
        m_brick = bus.brickHit;
      end else begin
        m_brick = m_brick | bus.brickHit;
      end
    end else begin
      if (bus.state == 3'b000) begin model_serve(); m_mode = 0; end
    end
  endtask

  // One clock: model follows the edge, outputs are then sampled at the falling edge
  task automatic cycle();
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic fly(input int n);
    for (int i = 0; i < n; i++) begin
      bus.state = 3'b001;
      bus.tick  = 1'b1;
      cycle();
    end
    bus.tick = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; bus.paddleX = 8'd40; bus.length = 8'd20; bus.state = 3'b000;
    cycle();
    checks++; if (bus.ballX !== 8'd50) begin errors++; $display("FAIL reset_x got %0d want 50", bus.ballX); end
    checks++; if (bus.ballY !== 7'd109) begin errors++; $display("FAIL reset_y got %0d want 109", bus.ballY); end
    checks++; if (bus.paddleHit !== 1'b0 || bus.lostBall !== 1'b0) begin errors++; $display("FAIL reset_pulses got %b%b want 00", bus.paddleHit, bus.lostBall); end
    resetn = 1'b1;
  endtask

  task automatic test_serve();
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++; if (bus.ballX !== 8'd50 || bus.ballY !== 7'd109) begin errors++; $display("FAIL serve_pos got %0d,%0d want 50,109", bus.ballX, bus.ballY); end
    end
    bus.paddleX = 8'd150; bus.length = 8'd40;
    cycle();
    checks++; if (bus.ballX !== 8'd159) begin errors++; $display("FAIL serve_saturate got %0d want 159", bus.ballX); end
    bus.paddleX = 8'd40; bus.length = 8'd20;
    cycle();
    checks++; if (bus.ballX !== 8'd50) begin errors++; $display("FAIL serve_follow got %0d want 50", bus.ballX); end
  endtask

  task automatic test_launch();
    bus.state = 3'b001; bus.tick = 1'b0;
    cycle();
    checks++; if (bus.ballX !== 8'd50 || bus.ballY !== 7'd109) begin errors++; $display("FAIL launch_enter got %0d,%0d want 50,109", bus.ballX, bus.ballY); end
    fly(1);
    checks++; if (bus.ballX !== 8'd51 || bus.ballY !== 7'd108) begin errors++; $display("FAIL launch_step got %0d,%0d want 51,108", bus.ballX, bus.ballY); end
    cycle();
    checks++; if (bus.ballX !== 8'd51 || bus.ballY !== 7'd108) begin errors++; $display("FAIL launch_no_tick got %0d,%0d want 51,108", bus.ballX, bus.ballY); end
  endtask

  task automatic test_paddle_hit();
    fly(108);
    checks++; if (bus.ballX !== 8'd159 || bus.ballY !== 7'd0) begin errors++; $display("FAIL corner got %0d,%0d want 159,0", bus.ballX, bus.ballY); end
    fly(109);
    checks++; if (bus.ballX !== 8'd50 || bus.ballY !== 7'd109) begin errors++; $display("FAIL descend got %0d,%0d want 50,109", bus.ballX, bus.ballY); end
    fly(1);
    checks++; if (bus.ballY !== 7'd108 || bus.ballX !== 8'd49) begin errors++; $display("FAIL paddle_bounce got %0d,%0d want 49,108", bus.ballX, bus.ballY); end
    checks++; if (bus.paddleHit !== 1'b1) begin errors++; $display("FAIL paddle_pulse got %b want 1", bus.paddleHit); end
    cycle();
    checks++; if (bus.paddleHit !== 1'b0) begin errors++; $display("FAIL paddle_pulse_end got %b want 0", bus.paddleHit); end
  endtask

  task automatic test_pause();
    bus.state = 3'b010; bus.tick = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    checks++; if (bus.ballX !== 8'd49 || bus.ballY !== 7'd108) begin errors++; $display("FAIL pause_freeze got %0d,%0d want 49,108", bus.ballX, bus.ballY); end
    fly(1);
    checks++; if (bus.ballX !== 8'd48 || bus.ballY !== 7'd107) begin errors++; $display("FAIL pause_resume got %0d,%0d want 48,107", bus.ballX, bus.ballY); end
  endtask

  task automatic test_right_wall();
    bus.state = 3'b000; bus.paddleX = 8'd150; bus.length = 8'd2;
    cycle();
    checks++; if (bus.ballX !== 8'd151 || bus.ballY !== 7'd109) begin errors++; $display("FAIL reserve got %0d,%0d want 151,109", bus.ballX, bus.ballY); end
    bus.state = 3'b001;
    cycle();
    fly(7);
    checks++; if (bus.ballX !== 8'd158 || bus.ballY !== 7'd102) begin errors++; $display("FAIL wall_approach got %0d,%0d want 158,102", bus.ballX, bus.ballY); end
    fly(1);
    checks++; if (bus.ballX !== 8'd159) begin errors++; $display("FAIL wall_clamp got %0d want 159", bus.ballX); end
    fly(1);
    checks++; if (bus.ballX !== 8'd158 || bus.ballY !== 7'd100) begin errors++; $display("FAIL wall_reflect got %0d,%0d want 158,100", bus.ballX, bus.ballY); end
  endtask

  task automatic test_paddle_miss();
    bus.state = 3'b000; bus.paddleX = 8'd51; bus.length = 8'd20;
    cycle();
    checks++; if (bus.ballX !== 8'd61) begin errors++; $display("FAIL miss_serve got %0d want 61", bus.ballX); end
    bus.state = 3'b001;
    cycle();
    bus.paddleX = 8'd40;
    fly(218);
    checks++; if (bus.ballX !== 8'd39 || bus.ballY !== 7'd109) begin errors++; $display("FAIL miss_descend got %0d,%0d want 39,109", bus.ballX, bus.ballY); end
    fly(1);
    checks++; if (bus.ballX !== 8'd38 || bus.ballY !== 7'd110 || bus.paddleHit !== 1'b0) begin errors++; $display("FAIL miss_pass got %0d,%0d hit=%b want 38,110 hit=0", bus.ballX, bus.ballY, bus.paddleHit); end
  endtask

  task automatic test_loss();
    fly(8);
    checks++; if (bus.ballY !== 7'd118 || bus.lostBall !== 1'b0) begin errors++; $display("FAIL loss_approach got y=%0d lost=%b want 118,0", bus.ballY, bus.lostBall); end
    fly(1);
    checks++; if (bus.ballX !== 8'd29 || bus.ballY !== 7'd119 || bus.lostBall !== 1'b1) begin errors++; $display("FAIL loss_bottom got %0d,%0d lost=%b want 29,119,1", bus.ballX, bus.ballY, bus.lostBall); end
    fly(3);
    checks++; if (bus.ballX !== 8'd29 || bus.ballY !== 7'd119 || bus.lostBall !== 1'b0) begin errors++; $display("FAIL loss_frozen got %0d,%0d lost=%b want 29,119,0", bus.ballX, bus.ballY, bus.lostBall); end
    bus.state = 3'b000;
    cycle();
    checks++; if (bus.ballX !== 8'd50 || bus.ballY !== 7'd109) begin errors++; $display("FAIL loss_reserve got %0d,%0d want 50,109", bus.ballX, bus.ballY); end
  endtask

  task automatic test_brick_top();
    bus.state = 3'b001;
    cycle();
    fly(108);
    checks++; if (bus.ballX !== 8'd158 || bus.ballY !== 7'd1) begin errors++; $display("FAIL brick_approach got %0d,%0d want 158,1", bus.ballX, bus.ballY); end
    bus.brickHit = 1'b1;
    cycle();
    bus.brickHit = 1'b0;
    fly(1);
    checks++; if (bus.ballX !== 8'd159 || bus.ballY !== 7'd0) begin errors++; $display("FAIL brick_top got %0d,%0d want 159,0", bus.ballX, bus.ballY); end
    fly(1);
    checks++; if (bus.ballX !== 8'd158 || bus.ballY !== 7'd1) begin errors++; $display("FAIL brick_single_flip got %0d,%0d want 158,1", bus.ballX, bus.ballY); end
    bus.brickHit = 1'b1;
    cycle();
    bus.brickHit = 1'b0;
    fly(2);
    checks++; if (bus.ballX !== 8'd156 || bus.ballY !== 7'd1) begin errors++; $display("FAIL brick_midair got %0d,%0d want 156,1", bus.ballX, bus.ballY); end
  endtask

  task automatic test_reset_mid_move();
    resetn = 1'b0; bus.tick = 1'b1;
    cycle();
    checks++; if (bus.ballX !== 8'd50 || bus.ballY !== 7'd109) begin errors++; $display("FAIL midreset got %0d,%0d want 50,109", bus.ballX, bus.ballY); end
    resetn = 1'b1; bus.tick = 1'b0;
    cycle();
    fly(1);
    checks++; if (bus.ballX !== 8'd51 || bus.ballY !== 7'd108) begin errors++; $display("FAIL midreset_relaunch got %0d,%0d want 51,108", bus.ballX, bus.ballY); end
  endtask

  task automatic test_random();
    int r, px;
    for (int n = 0; n < 4000; n++) begin
      r = int'($urandom_range(0, 99));
      resetn = (r == 0) ? 1'b0 : 1'b1;
      if (r < 90) bus.state = 3'b001;
      else if (r < 94) bus.state = 3'b000;
      else bus.state = 3'($urandom_range(2, 7));
      bus.tick = 1'($urandom_range(0, 1));
      bus.brickHit = ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 19) == 0) bus.length = 8'($urandom_range(1, 60));
      if ($urandom_range(0, 4) != 0) begin
        px = m_x - int'($urandom_range(0, int'(bus.length) - 1));
        if (px < 0) px = 0;
        bus.paddleX = 8'(px);
      end else begin
        bus.paddleX = 8'($urandom_range(0, 200));
      end
      cycle();
      checks++; if (bus.ballX !== 8'(m_x)) begin errors++; $display("FAIL rand_x n=%0d got %0d want %0d", n, bus.ballX, m_x); end
      checks++; if (bus.ballY !== 7'(m_y)) begin errors++; $display("FAIL rand_y n=%0d got %0d want %0d", n, bus.ballY, m_y); end
      checks++; if (bus.paddleHit !== m_phit) begin errors++; $display("FAIL rand_hit n=%0d got %b want %b", n, bus.paddleHit, m_phit); end
      checks++; if (bus.lostBall !== m_lost) begin errors++; $display("FAIL rand_lost n=%0d got %b want %b", n, bus.lostBall, m_lost); end
    end
  endtask

  // Scenario sequence and summary
  initial begin
    resetn = 1'b0;
    bus.tick = 1'b0; bus.state = 3'b000; bus.brickHit = 1'b0;
    bus.paddleX = 8'd40; bus.length = 8'd20;
    m_mode = 0; m_x = 0; m_y = 0; m_dx = 1; m_dy = -1; m_brick = 0; m_phit = 0; m_lost = 0;
    @(negedge clock);
    test_reset();
    test_serve();
    test_launch();
    test_paddle_hit();
    test_pause();
    test_right_wall();
    test_paddle_miss();
    test_loss();
    test_brick_top();
    test_reset_mid_move();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
